out_display: RTL and testbench

//  Output register plus 4-digit multiplexed 7-segment driver; sits downstream of the

---
 rtl/out_display.sv | 161 ++++++++++++++++
 tb/tb_out_display.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_display.sv
// Output register with sequential binary-to-BCD and a 4-digit multiplexed
// common-anode 7-segment driver.
// Optional feature macro: OUT_SIGNED_EN (two's-complement value, minus on digit 3).
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus, out_en  data bus and capture strobe (level sampled)
//   value        latched register contents
//   busy         conversion in progress
//   seg, an      segments {g..a} and digit enables, both active-low
module out_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] bus,
  input  logic       out_en,
  output logic [7:0] value,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an
);

  localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(REFRESH_DIV - 1);
  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e        state_q, state_d;
  logic [7:0]    value_q, value_d;
  logic [19:0]   sr_q, sr_d;
  logic [2:0]    iter_q, iter_d;
  logic [11:0]   bcd_q, bcd_d;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    idx_q, idx_d;
  logic [7:0]    mag;

`ifdef OUT_SIGNED_EN
  // 8-bit negate keeps 0x80 as 128
  assign mag = bus[7] ? 8'(~bus + 8'd1) : bus;
`else
  assign mag = bus;
`endif

  // One double-dabble iteration: correct each BCD nibble, then shift
  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    if (r[11:8]  >= 4'd5) r[11:8]  = r[11:8]  + 4'd3;
    if (r[15:12] >= 4'd5) r[15:12] = r[15:12] + 4'd3;
    if (r[19:16] >= 4'd5) r[19:16] = r[19:16] + 4'd3;
    return {r[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] dec7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = BLANK;
    endcase
    return s;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: a capture restarts from any state
  always_comb begin
    state_d = state_q;
    if (out_en) begin
      state_d = SHIFT;
    end else begin
      case (state_q)
        SHIFT:   if (iter_q == 3'd7) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs of the FSM
  always_comb begin
    busy = (state_q != IDLE);
  end

  // Datapath and scan next-state
  always_comb begin
    value_d = value_q;
    sr_d    = sr_q;
    iter_d  = iter_q;
    bcd_d   = bcd_q;
    if (out_en) begin
      value_d = bus;
      sr_d    = {12'b0, mag};
      iter_d  = 3'd0;
    end else if (state_q == SHIFT) begin
      sr_d    = dabble(sr_q);
      iter_d  = iter_q + 3'd1;
    end else if (state_q == DONE) begin
      bcd_d   = sr_q[19:8];
    end
    if (div_q == DIV_MAX) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + DW'(1);
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      value_q <= 8'd0;
      sr_q    <= 20'd0;
      iter_q  <= 3'd0;
      bcd_q   <= 12'd0;
      div_q   <= '0;
      idx_q   <= 2'd0;
    end else begin
      value_q <= value_d;
      sr_q    <= sr_d;
      iter_q  <= iter_d;
      bcd_q   <= bcd_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
    end
  end

  assign value = value_q;
  assign an    = ~(4'b0001 << idx_q);

  always_comb begin
    seg = BLANK;
    unique case (idx_q)
      2'd0: seg = dec7(bcd_q[3:0]);
      2'd1: seg = (bcd_q[11:4] == 8'd0) ? BLANK : dec7(bcd_q[7:4]);
      2'd2: seg = (bcd_q[11:8] == 4'd0) ? BLANK : dec7(bcd_q[11:8]);
      2'd3: begin
`ifdef OUT_SIGNED_EN
        seg = value_q[7] ? MINUS : BLANK;
`else
        seg = BLANK;
`endif
      end
    endcase
  end

endmodule

// File: tb/tb_out_display.sv
// Self-checking bench for out_display: random and directed captures
// compared against a decimal reference model, plus scan sequencing.
module tb_out_display;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       out_en = 1'b0;
  logic [7:0] bus = 8'd0;

  logic [7:0] v1, v4;
  logic       b1, b4;
  logic [6:0] s1, s4;
  logic [3:0] a1, a4;

  int checks = 0;
  int failures = 0;

  out_display #(.REFRESH_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus), .out_en(out_en),
    .value(v1), .busy(b1), .seg(s1), .an(a1)
  );

  out_display #(.REFRESH_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .bus(bus), .out_en(out_en),
    .value(v4), .busy(b4), .seg(s4), .an(a4)
  );

  function automatic logic [6:0] dec(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  // Reference: decimal digits of the captured value, with blanking
  function automatic logic [6:0] exp_seg(input logic [7:0] v, input int pos);
    int m, h, t, o;
    bit neg;
    m = int'(v);
    neg = 1'b0;
`ifdef OUT_SIGNED_EN
    if (m >= 128) begin
      m = 256 - m;
      neg = 1'b1;
    end
`endif
    h = m / 100;
    t = (m / 10) % 10;
    o = m % 10;
    case (pos)
      0: return dec(o);
      1: return (h == 0 && t == 0) ? 7'b1111111 : dec(t);
      2: return (h == 0) ? 7'b1111111 : dec(h);
      default: return neg ? 7'b0111111 : 7'b1111111;
    endcase
  endfunction

  // Drive a one-cycle capture, then count busy cycles (bounded)
  task automatic capture(input logic [7:0] v, output int n);
    bus = v;
    out_en = 1'b1;
    @(negedge clk);
    out_en = 1'b0;
    n = 0;
    while (b1 === 1'b1 && n < 30) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic check_display(input logic [7:0] v, input string nm);
    logic [6:0] got [4];
    for (int p = 0; p < 4; p++) got[p] = 7'bxxxxxxx;
    for (int i = 0; i < 4; i++) begin
      case (a1)
        4'b1110: got[0] = s1;
        4'b1101: got[1] = s1;
        4'b1011: got[2] = s1;
        4'b0111: got[3] = s1;
        default: ;
      endcase
      @(negedge clk);
    end
    for (int p = 0; p < 4; p++) begin
      checks++;
      if (got[p] !== exp_seg(v, p)) begin
        failures++;
        $display("FAIL %s v=%02h digit%0d seg=%b expected=%b",
                 nm, v, p, got[p], exp_seg(v, p));
      end
    end
  endtask

  task automatic convert_and_check(input logic [7:0] v, input string nm);
    int n;
    capture(v, n);
    checks++;
    if (n !== 9) begin
      failures++;
      $display("FAIL %s_busy v=%02h cycles=%0d expected=9", nm, v, n);
    end
    checks++;
    if (v1 !== v) begin
      failures++;
      $display("FAIL %s_value got=%02h expected=%02h", nm, v1, v);
    end
    check_display(v, nm);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    out_en = 1'b0;
    @(negedge clk);
    bus = 8'h55;
    out_en = 1'b1;
    @(negedge clk);
    checks++;
    if (v1 !== 8'd0 || b1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_state value=%02h busy=%b expected 00/0", v1, b1);
    end
    checks++;
    if (a1 !== 4'b1110 || s1 !== 7'b1000000) begin
      failures++;
      $display("FAIL reset_disp an=%b seg=%b expected 1110/1000000", a1, s1);
    end
    checks++;
    if (a4 !== 4'b1110 || v4 !== 8'd0) begin
      failures++;
      $display("FAIL reset_dut4 an=%b value=%02h expected 1110/00", a4, v4);
    end
    out_en = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_max();
    convert_and_check(8'hFF, "max");
`ifndef OUT_SIGNED_EN
    checks++;
    if (exp_seg(8'hFF, 2) !== 7'b0100100 || s1 === 7'bxxxxxxx) begin
      failures++;
      $display("FAIL max_model seg=%b expected=0100100", exp_seg(8'hFF, 2));
    end
`endif
  endtask

  task automatic test_blanking();
    convert_and_check(8'h07, "blank7");
    convert_and_check(8'h00, "blank0");
    convert_and_check(8'h0A, "blank10");
    convert_and_check(8'h64, "blank100");
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) begin
      convert_and_check(8'($urandom_range(0, 255)), "random");
    end
  endtask

  task automatic test_restart();
    int n;
    convert_and_check(8'h07, "pre_restart");
    bus = 8'h64;
    out_en = 1'b1;
    @(negedge clk);
    out_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (b1 !== 1'b1) begin
        failures++;
        $display("FAIL restart_busy_pre busy=%b expected=1", b1);
      end
      @(negedge clk);
    end
    bus = 8'h2A;
    out_en = 1'b1;
    @(negedge clk);
    out_en = 1'b0;
    n = 0;
    while (b1 === 1'b1 && n < 30) begin
      n++;
      checks++;
      if ((a1 == 4'b1011 && s1 !== 7'b1111111) ||
          (a1 == 4'b1101 && s1 !== 7'b1111111 && s1 !== dec(4))) begin
        failures++;
        $display("FAIL restart_abort_shown an=%b seg=%b", a1, s1);
      end
      @(negedge clk);
    end
    checks++;
    if (n !== 9) begin
      failures++;
      $display("FAIL restart_busy cycles=%0d expected=9", n);
    end
    check_display(8'h2A, "restart");
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] a, b;
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    bus = a;
    out_en = 1'b1;
    @(negedge clk);
    capture(b, n);
    checks++;
    if (n !== 9) begin
      failures++;
      $display("FAIL b2b_busy cycles=%0d expected=9", n);
    end
    checks++;
    if (v1 !== b) begin
      failures++;
      $display("FAIL b2b_value got=%02h expected=%02h", v1, b);
    end
    check_display(b, "b2b");
  endtask

`ifdef OUT_SIGNED_EN
  task automatic test_signed();
    convert_and_check(8'h80, "signed_m128");
    convert_and_check(8'hFF, "signed_m1");
    convert_and_check(8'h7F, "signed_127");
  endtask
`endif

  task automatic test_scan();
    logic [3:0] e;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 22; k++) begin
      e = ~(4'b0001 << ((k / 4) % 4));
      checks++;
      if (a4 !== e) begin
        failures++;
        $display("FAIL scan k=%0d an=%b expected=%b", k, a4, e);
      end
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (a4 !== 4'b1110) begin
      failures++;
      $display("FAIL scan_reset an=%b expected=1110", a4);
    end
  endtask

  initial begin
    test_reset();
    test_max();
    test_blanking();
    test_random();
    test_restart();
    test_back_to_back();
`ifdef OUT_SIGNED_EN
    test_signed();
`endif
    test_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
